// File: rtl/baud_tick_gen_if.sv
// rtl/baud_tick_gen_if.sv - register-write and tick bus for baud_tick_gen
//
// Purpose: groups the enable, divisor write port and tick outputs of the
//          baud rate generator.
// Signals:
//   en       count enable (master -> slave)
//   wr       divisor write strobe (master -> slave)
//   ioaddr   register select, 2'b10 low byte, 2'b11 high byte
//   wdata    write data byte
//   divisor  current divisor register (slave -> master)
//   rx_tick  one-cycle oversample enable (slave -> master)
//   tx_tick  one-cycle bit-rate enable (slave -> master)

interface baud_tick_gen_if #(
   parameter int DIV_W = 16
);
   logic             en;
   logic             wr;
   logic [1:0]       ioaddr;
   logic [7:0]       wdata;
   logic [DIV_W-1:0] divisor;
   logic             rx_tick;
   logic             tx_tick;

   modport master (
      output en, wr, ioaddr, wdata,
      input  divisor, rx_tick, tx_tick
   );

   modport slave (
      input  en, wr, ioaddr, wdata,
      output divisor, rx_tick, tx_tick
   );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - programmable baud rate tick generator
//
// Purpose: down counter reloaded from a byte-writable divisor produces an
//          oversample tick every divisor+1 cycles; a prescaler divides that
//          by OVERSAMPLE to give the bit-rate tick.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   baud_tick_gen_if.slave: en, wr, ioaddr, wdata in;
//         divisor, rx_tick, tx_tick out

module baud_tick_gen #(
   parameter int          DIV_W       = 16,
   parameter int          OVERSAMPLE  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
   input logic           clk,
   input logic           rst,
   baud_tick_gen_if.slave bus
);
   localparam int               PS_W    = $clog2(OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_RST = DEFAULT_DIV[DIV_W-1:0];
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(OVERSAMPLE - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_new;
   logic [DIV_W-1:0] cnt;
   logic [PS_W-1:0]  ps;
   logic             div_wr;
   logic             rx_tick;

   // Merge the written byte into the current divisor so a single byte
   // write restarts the phase with the combined value.
   always_comb begin
      div_new = div_q;
      div_wr  = 1'b0;
      if (bus.wr) begin
         case (bus.ioaddr)
            2'b10: begin
               div_new[7:0] = bus.wdata;
               div_wr       = 1'b1;
            end
            2'b11: begin
               div_new[DIV_W-1:8] = bus.wdata[DIV_W-9:0];
               div_wr             = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Gated by rst so no stale terminal count leaks out while in reset.
   assign rx_tick     = !rst && bus.en && (cnt == '0) && (div_q != '0);
   assign bus.rx_tick = rx_tick;
   assign bus.tx_tick = rx_tick && (ps == PS_LAST);
   assign bus.divisor = div_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= DIV_RST;
         cnt   <= DIV_RST;
         ps    <= '0;
      end else if (div_wr) begin
         // A write wins over a coincident tick: ps clears, not increments.
         div_q <= div_new;
         cnt   <= div_new;
         ps    <= '0;
      end else if (bus.en) begin
         // Reload at zero, so the decrement never underflows.
         if (cnt == '0) begin
            cnt <= div_q;
         end else begin
            cnt <= cnt - 1'b1;
         end
         if (rx_tick) begin
            ps <= (ps == PS_LAST) ? '0 : ps + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - scoreboard testbench for baud_tick_gen

module tb_baud_tick_gen;
   localparam int DIV_W = 16;

   typedef struct {
      int   cyc;
      logic tx;
   } tick_t;

   typedef struct {
      int               cyc;
      logic [DIV_W-1:0] val;
   } div_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc;
   int   checks = 0;
   int   passes = 0;
   logic armed = 1'b0;
   logic armed_d = 1'b0;

   tick_t exp_q[$];
   div_t  dexp_q[$];

   baud_tick_gen_if #(.DIV_W(DIV_W)) bus ();

   baud_tick_gen #(
      .DIV_W      (DIV_W),
      .OVERSAMPLE (4),
      .DEFAULT_DIV(16'd4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   // Cycle k is the interval after the k-th edge following the last reset edge.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   // Monitor: every comparison lives here.
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (!bus.rx_tick && !bus.tx_tick) passes++;
         else $display("FAIL tick_in_reset rx=%0b tx=%0b required 0/0", bus.rx_tick, bus.tx_tick);
      end else if (armed && (bus.rx_tick || bus.tx_tick)) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL tick_unexpected cyc=%0d rx=%0b tx=%0b required no tick",
                     cyc, bus.rx_tick, bus.tx_tick);
         end else begin
            tick_t e;
            e = exp_q.pop_front();
            if (cyc == e.cyc && bus.rx_tick && bus.tx_tick == e.tx) passes++;
            else $display("FAIL tick_match cyc=%0d rx=%0b tx=%0b required cyc=%0d rx=1 tx=%0b",
                          cyc, bus.rx_tick, bus.tx_tick, e.cyc, e.tx);
         end
      end
      if (armed && dexp_q.size() != 0 && dexp_q[0].cyc == cyc) begin
         div_t d;
         d = dexp_q.pop_front();
         checks++;
         if (bus.divisor == d.val) passes++;
         else $display("FAIL divisor cyc=%0d got=%h required=%h", cyc, bus.divisor, d.val);
      end
      if (armed_d && !armed) begin
         checks++;
         if (exp_q.size() == 0 && dexp_q.size() == 0) passes++;
         else $display("FAIL phase_leftover ticks=%0d div=%0d required 0/0",
                       exp_q.size(), dexp_q.size());
         exp_q.delete();
         dexp_q.delete();
      end
      armed_d <= armed;
   end

   task automatic wait_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset for two edges; optionally with a write and en=0 pending to show rst wins.
   task automatic do_reset(input bit dirty);
      @(posedge clk);
      #1;
      armed  = 1'b0;
      rst    = 1'b1;
      bus.wr = dirty;
      bus.en = !dirty;
      bus.ioaddr = 2'b10;
      bus.wdata  = 8'h55;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      bus.wr = 1'b0;
      bus.en = 1'b1;
   endtask

   task automatic wr_reg(input int k, input logic [1:0] a, input logic [7:0] d);
      wait_cyc(k);
      bus.wr     = 1'b1;
      bus.ioaddr = a;
      bus.wdata  = d;
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
   endtask

   task automatic exp_tick(input int c, input logic t);
      tick_t e;
      e.cyc = c;
      e.tx  = t;
      exp_q.push_back(e);
   endtask

   task automatic exp_div(input int c, input logic [DIV_W-1:0] v);
      div_t d;
      d.cyc = c;
      d.val = v;
      dexp_q.push_back(d);
   endtask

   task automatic end_phase(input int k);
      wait_cyc(k);
      armed = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.en     = 1'b1;
      bus.wr     = 1'b0;
      bus.ioaddr = 2'b00;
      bus.wdata  = 8'h00;

      // Default run: period 5, tx every 4th rx tick.
      do_reset(1'b0);
      exp_div(0, 16'd4);
      exp_tick(4, 0);  exp_tick(9, 0);  exp_tick(14, 0); exp_tick(19, 1);
      exp_tick(24, 0); exp_tick(29, 0); exp_tick(34, 0); exp_tick(39, 1);
      armed = 1'b1;
      end_phase(42);

      // Two byte writes restart the phase; divisor becomes 2.
      do_reset(1'b0);
      exp_tick(4, 0);
      exp_div(8, 16'd2);
      exp_tick(10, 0); exp_tick(13, 0); exp_tick(16, 0); exp_tick(19, 1);
      exp_tick(22, 0); exp_tick(25, 0); exp_tick(28, 0); exp_tick(31, 1);
      armed = 1'b1;
      wr_reg(6, 2'b10, 8'h02);
      wr_reg(7, 2'b11, 8'h00);
      end_phase(33);

      // en low for 5 cycles starting at cnt=2 delays everything by 5.
      do_reset(1'b0);
      exp_tick(9, 0);  exp_tick(14, 0); exp_tick(19, 0); exp_tick(24, 1);
      exp_tick(29, 0); exp_tick(34, 0); exp_tick(39, 0); exp_tick(44, 1);
      armed = 1'b1;
      wait_cyc(2);
      bus.en = 1'b0;
      wait_cyc(7);
      bus.en = 1'b1;
      end_phase(46);

      // Divisor zero silences ticks; then divisor 1 gives period 2.
      do_reset(1'b0);
      exp_div(50, 16'd0);
      exp_tick(104, 0); exp_tick(106, 0); exp_tick(108, 0); exp_tick(110, 1);
      exp_tick(112, 0); exp_tick(114, 0); exp_tick(116, 0); exp_tick(118, 1);
      armed = 1'b1;
      wr_reg(0, 2'b10, 8'h00);
      wr_reg(1, 2'b11, 8'h00);
      wr_reg(102, 2'b10, 8'h01);
      end_phase(120);

      // Writes to ignored addresses and a write/en=0 held during reset.
      do_reset(1'b1);
      exp_tick(4, 0); exp_tick(9, 0); exp_tick(14, 0); exp_tick(19, 1);
      exp_div(20, 16'd4);
      armed = 1'b1;
      wr_reg(2, 2'b00, 8'hFF);
      wr_reg(3, 2'b01, 8'hFF);
      end_phase(21);

      // Write coinciding with tx_tick: tx still seen, ps restarts.
      do_reset(1'b0);
      exp_tick(4, 0);  exp_tick(9, 0);  exp_tick(14, 0); exp_tick(19, 1);
      exp_div(21, 16'd2);
      exp_tick(22, 0); exp_tick(25, 0); exp_tick(28, 0); exp_tick(31, 1);
      armed = 1'b1;
      wr_reg(19, 2'b10, 8'h02);
      end_phase(33);

      // Full 16-bit change: high byte then low byte, period uses 0x0103.
      do_reset(1'b0);
      exp_div(2, 16'h0103);
      exp_tick(261, 0); exp_tick(521, 0); exp_tick(781, 0); exp_tick(1041, 1);
      armed = 1'b1;
      wr_reg(0, 2'b11, 8'h01);
      wr_reg(1, 2'b10, 8'h03);
      end_phase(1043);

      @(negedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16: divisor and counter width, legal range 9..16.
REQ-002 Parameter OVERSAMPLE, default 16: rx ticks per tx tick, legal range 2..32.
REQ-003 Parameter DEFAULT_DIV, default 16'd325: divisor value loaded at reset, truncated to DIV_W bits.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  count enable; low freezes the counter and the prescaler.
REQ-007 wr  input  1  divisor write strobe, sampled each cycle.
REQ-008 ioaddr  input  2  register select: 2'b10 is divisor low byte, 2'b11 is divisor high byte; other values are ignored.
REQ-009 wdata  input  8  write data.
REQ-010 divisor  output  DIV_W  current divisor register.
REQ-011 rx_tick  output  1  one-cycle oversample enable.
REQ-012 tx_tick  output  1  one-cycle bit-rate enable, every OVERSAMPLE rx ticks.

Function
REQ-013 The divisor register SHALL take divisor[7:0] <= wdata on a cycle with wr=1 and ioaddr=2'b10.
REQ-014 The divisor register SHALL take divisor[DIV_W-1:8] <= wdata[DIV_W-9:0] on a cycle with wr=1 and ioaddr=2'b11; the upper wdata bits are discarded.
REQ-015 A write with wr=1 and ioaddr in {00,01} SHALL change no state.
REQ-016 The down counter cnt[DIV_W-1:0] SHALL update with the following priority, highest first:
  - divisor write: cnt loads the merged new divisor value and the prescaler clears to 0; this applies regardless of en.
  - en=0: cnt and the prescaler hold.
  - cnt==0: cnt loads divisor.
  - otherwise: cnt decrements by 1.
REQ-017 rx_tick SHALL be the combinational value en && (cnt==0) && (divisor!=0).
REQ-018 A nonzero divisor D SHALL give an rx_tick period of exactly D+1 clk cycles while en=1.
REQ-019 divisor==0 SHALL disable both rx_tick and tx_tick; cnt stays at 0.
REQ-020 The prescaler ps SHALL be $clog2(OVERSAMPLE) bits wide.
REQ-021 On each rx_tick, ps SHALL increment and wrap from OVERSAMPLE-1 to 0.
REQ-022 tx_tick SHALL be the combinational value rx_tick && (ps==OVERSAMPLE-1), so it coincides with every OVERSAMPLE-th rx_tick.
REQ-023 A divisor write in the same cycle as rx_tick SHALL leave rx_tick asserted in that cycle, and tx_tick per REQ-022; on the following edge, the write takes priority and ps clears rather than incrementing.
REQ-024 A full 16-bit change written as two byte writes SHALL restart the phase twice; the period after the second write uses the fully merged value.
REQ-025 The counter SHALL wrap-free: no arithmetic underflow is possible, because reload occurs at 0.

Reset
REQ-026 On an rst=1 edge, the block SHALL set divisor=DEFAULT_DIV, cnt=DEFAULT_DIV and ps=0.
REQ-027 rst SHALL override wr and en in the same cycle.
REQ-028 While rst=1, and in the first cycle after it, rx_tick and tx_tick SHALL be 0 for any DEFAULT_DIV>0.
REQ-029 Reset asserted mid-period SHALL discard the current phase; the first rx_tick follows DEFAULT_DIV cycles after release.

Verification
REQ-030 With DEFAULT_DIV=4, OVERSAMPLE=4 and en=1, released from reset at edge 0: rx_tick is high in cycles 4, 9, 14 and 19; tx_tick is high only in cycle 19, then again in cycle 39.
REQ-031 Writing 0x02 to ioaddr 10 at cycle 6 and 0x00 to ioaddr 11 at cycle 7 (DEFAULT_DIV=4): cnt=2 after cycle 7; rx_tick in cycles 10, 13, 16; ps is 0 at cycle 8.
REQ-032 en dropped for 5 cycles at cnt=2: rx_tick is delayed by exactly 5 cycles and the period is otherwise unchanged; ps is unchanged.
REQ-033 Write 0x00 to both divisor bytes: no rx_tick and no tx_tick for 100 cycles; then writing 0x01 to the low byte gives rx_tick every 2 cycles.
REQ-034 A write to ioaddr 00 or 01 with wr=1 and wdata=0xFF: divisor and the tick timing are unchanged versus a reference run.
REQ-035 A divisor write coinciding with rx_tick at ps=OVERSAMPLE-1: tx_tick=1 in that cycle; ps=0 after the edge; the next tx_tick follows OVERSAMPLE further rx ticks.
